// File: rtl/rv_div_unit_pkg.sv
// Shared constants and opcode helpers for the RV32M iterative divide unit.
package rv_div_unit_pkg;

    localparam int DIV_XLEN   = 32;
    localparam int DIV_REG_AW = 5;

    localparam logic [1:0] DIV_OP_DIV  = 2'b00;
    localparam logic [1:0] DIV_OP_DIVU = 2'b01;
    localparam logic [1:0] DIV_OP_REM  = 2'b10;
    localparam logic [1:0] DIV_OP_REMU = 2'b11;

    localparam logic [DIV_REG_AW-1:0] X0        = '0;
    localparam logic [DIV_XLEN-1:0]   ZERO_WORD = '0;

    function automatic logic isSignedOp(input logic [1:0] op);
        logic r;
        case (op)
            DIV_OP_DIV, DIV_OP_REM:   r = 1'b1;
            DIV_OP_DIVU, DIV_OP_REMU: r = 1'b0;
            default:                  r = 1'b0;
        endcase
        return r;
    endfunction

    function automatic logic isRemOp(input logic [1:0] op);
        return (op == DIV_OP_REM) || (op == DIV_OP_REMU);
    endfunction

endpackage

// File: rtl/rv_div_unit_if.sv
// Execute-stage port bundle between the pipeline and the divide unit.
// Handshake: Start is taken only while the unit is idle (Busy low); Done is a one-cycle pulse with Result/AddrRdOut valid.
interface rv_div_unit_if
    import rv_div_unit_pkg::*;
#(
    parameter int XLEN   = DIV_XLEN,
    parameter int REG_AW = DIV_REG_AW
);
    logic              Start;
    logic [1:0]        Op;
    logic [XLEN-1:0]   Dividend;
    logic [XLEN-1:0]   Divisor;
    logic [REG_AW-1:0] AddrRdIn;
    logic              Flush;
    logic              Busy;
    logic              Done;
    logic [XLEN-1:0]   Result;
    logic [REG_AW-1:0] AddrRdOut;
    logic              RegWrite;

    modport master (
        output Start, Op, Dividend, Divisor, AddrRdIn, Flush,
        input  Busy, Done, Result, AddrRdOut, RegWrite
    );

    modport slave (
        input  Start, Op, Dividend, Divisor, AddrRdIn, Flush,
        output Busy, Done, Result, AddrRdOut, RegWrite
    );
endinterface

// File: rtl/rv_div_step.sv
// One restoring radix-2 division step: shift the next quotient bit into the remainder, subtract if it fits.
module rv_div_step #(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] RemIn,
    input  logic [XLEN-1:0] QuoIn,
    input  logic [XLEN-1:0] Divisor,
    output logic [XLEN-1:0] RemOut,
    output logic [XLEN-1:0] QuoOut
);
    logic [XLEN:0]   shifted;
    logic [XLEN-1:0] diffLo;
    logic            fits;

    // The extra top bit keeps the compare exact when the shifted remainder overflows XLEN bits.
    assign shifted = {RemIn, QuoIn[XLEN-1]};
    assign fits    = shifted >= {1'b0, Divisor};
    assign diffLo  = shifted[XLEN-1:0] - Divisor;
    assign RemOut  = fits ? diffLo : shifted[XLEN-1:0];
    assign QuoOut  = {QuoIn[XLEN-2:0], fits};
endmodule

// File: rtl/rv_div_unit.sv
// Iterative DIV/DIVU/REM/REMU unit: magnitude division over XLEN restoring steps, sign fix-up, one-cycle Done.
module rv_div_unit
    import rv_div_unit_pkg::*;
#(
    parameter int XLEN   = DIV_XLEN,
    parameter int REG_AW = DIV_REG_AW
) (
    input  logic        Clk,
    input  logic        Rst,
    rv_div_unit_if.slave divBus,
    output logic [1:0]  DbgState
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_FIX  = 2'd2;
    localparam logic [1:0] S_FAST = 2'd3;

    localparam int              CNT_W    = $clog2(XLEN);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(XLEN - 1);
    localparam logic [XLEN-1:0] MIN_NEG  = {1'b1, {(XLEN-1){1'b0}}};

    logic [1:0]        state;
    logic [CNT_W-1:0]  cnt;
    logic [XLEN-1:0]   remReg, quoReg, dvsrReg;
    logic [XLEN-1:0]   remNext, quoNext;
    logic              remSel, negQ, negR, done;
    logic [REG_AW-1:0] addrReg;
    logic [XLEN-1:0]   result;
    logic [REG_AW-1:0] addrOut;

    logic              opSigned, aNeg, bNeg, divZero, overflow, accept;
    logic [XLEN-1:0]   aAbs, bAbs, fastRes, qFinal, rFinal;

    always_comb begin
        opSigned = isSignedOp(divBus.Op);
        aNeg     = opSigned & divBus.Dividend[XLEN-1];
        bNeg     = opSigned & divBus.Divisor[XLEN-1];
        aAbs     = aNeg ? -divBus.Dividend : divBus.Dividend;
        bAbs     = bNeg ? -divBus.Divisor : divBus.Divisor;
        divZero  = (divBus.Divisor == '0);
        overflow = opSigned & (divBus.Dividend == MIN_NEG) & (divBus.Divisor == '1);
        // Special cases bypass the iteration; div-by-zero remainder is the raw dividend even for signed ops.
        fastRes  = '0;
        if (isRemOp(divBus.Op)) fastRes = divZero ? divBus.Dividend : '0;
        else                    fastRes = divZero ? '1 : MIN_NEG;
        // A Done still high means the unit just finished; a Start in that cycle is dropped.
        accept   = (state == S_IDLE) & divBus.Start & ~divBus.Flush & ~done;
        qFinal   = negQ ? -quoReg : quoReg;
        rFinal   = negR ? -remReg : remReg;
    end

    rv_div_step #(.XLEN(XLEN)) u_step (
        .RemIn   (remReg),
        .QuoIn   (quoReg),
        .Divisor (dvsrReg),
        .RemOut  (remNext),
        .QuoOut  (quoNext)
    );

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state   <= S_IDLE;
            cnt     <= '0;
            remReg  <= '0;
            quoReg  <= '0;
            dvsrReg <= '0;
            remSel  <= 1'b0;
            negQ    <= 1'b0;
            negR    <= 1'b0;
            addrReg <= '0;
            done    <= 1'b0;
            result  <= XLEN'(ZERO_WORD);
            addrOut <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        remSel  <= isRemOp(divBus.Op);
                        negQ    <= aNeg ^ bNeg;
                        negR    <= aNeg;
                        addrReg <= divBus.AddrRdIn;
                        remReg  <= '0;
                        quoReg  <= aAbs;
                        dvsrReg <= bAbs;
                        cnt     <= '0;
                        if (divZero | overflow) begin
                            // FAST is the Done cycle itself, so Done lands one cycle after Start.
                            state   <= S_FAST;
                            result  <= fastRes;
                            addrOut <= divBus.AddrRdIn;
                            done    <= 1'b1;
                        end else begin
                            state <= S_CALC;
                        end
                    end
                end
                S_CALC: begin
                    if (divBus.Flush) begin
                        state <= S_IDLE;
                    end else begin
                        remReg <= remNext;
                        quoReg <= quoNext;
                        cnt    <= cnt + 1'b1;
                        if (cnt == CNT_LAST) state <= S_FIX;
                    end
                end
                S_FIX: begin
                    state <= S_IDLE;
                    if (!divBus.Flush) begin
                        result  <= remSel ? rFinal : qFinal;
                        addrOut <= addrReg;
                        done    <= 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign divBus.Busy      = (state != S_IDLE) | done;
    assign divBus.Done      = done;
    assign divBus.Result    = result;
    assign divBus.AddrRdOut = addrOut;
    assign divBus.RegWrite  = done & (addrOut != REG_AW'(X0));
    assign DbgState         = state;
endmodule

// File: tb/tb_rv_div_unit.sv
// Self-checking bench for rv_div_unit: directed corner cases plus random ops against an arithmetic reference.
module tb_rv_div_unit;
    localparam int XLEN     = 32;
    localparam int REG_AW   = 5;
    localparam int LAT_NORM = XLEN + 2;
    localparam int BUDGET   = 60;

    logic Clk = 1'b0;
    logic Rst = 1'b1;
    logic [1:0] dbgState;

    int nVectors = 0;
    int nMiss    = 0;
    logic [XLEN-1:0] exp_q[$];

    rv_div_unit_if #(.XLEN(XLEN), .REG_AW(REG_AW)) divBus ();

    rv_div_unit #(.XLEN(XLEN), .REG_AW(REG_AW)) dut (
        .Clk      (Clk),
        .Rst      (Rst),
        .divBus   (divBus),
        .DbgState (dbgState)
    );

    always #5 Clk = ~Clk;

    task automatic checkVal(input string tag, input logic [XLEN-1:0] obs, input logic [XLEN-1:0] exp);
        nVectors++;
        if (obs !== exp) begin
            nMiss++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference: RISC-V M-extension semantics straight from the ISA rules, truncating division.
    function automatic logic [XLEN-1:0] refDiv(input logic [1:0] op, input logic [XLEN-1:0] a,
                                               input logic [XLEN-1:0] b);
        logic signed [XLEN-1:0] sa, sb, sq, sr;
        logic ovf;
        sa  = a;
        sb  = b;
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        if (b == 0) return (op[1]) ? a : 32'hFFFF_FFFF;
        if (op == 2'b00) begin
            if (ovf) return 32'h8000_0000;
            sq = sa / sb;
            return sq;
        end
        if (op == 2'b10) begin
            if (ovf) return 32'h0;
            sr = sa % sb;
            return sr;
        end
        if (op == 2'b01) return a / b;
        return a % b;
    endfunction

    function automatic int refLat(input logic [1:0] op, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b);
        logic sgn;
        sgn = (op == 2'b00) || (op == 2'b10);
        if (b == 0) return 1;
        if (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
        return LAT_NORM;
    endfunction

    task automatic drive(input logic [1:0] op, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                         input logic [REG_AW-1:0] rd);
        divBus.Start    = 1'b1;
        divBus.Op       = op;
        divBus.Dividend = a;
        divBus.Divisor  = b;
        divBus.AddrRdIn = rd;
    endtask

    // Launch one op at the current negedge and follow it to Done; pokeAt > 0 pulses a stray Start mid-op.
    task automatic runOp(input logic [1:0] op, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                         input logic [REG_AW-1:0] rd, input int pokeAt);
        int cyc;
        int lat;
        int busyGaps;
        logic [XLEN-1:0] expRes;
        lat = refLat(op, a, b);
        exp_q.push_back(refDiv(op, a, b));
        drive(op, a, b, rd);
        @(posedge Clk);
        @(negedge Clk);
        divBus.Start = 1'b0;
        cyc      = 1;
        busyGaps = 0;
        while (!divBus.Done && cyc < BUDGET) begin
            if (!divBus.Busy) busyGaps++;
            divBus.Start = (pokeAt > 0) && (cyc == pokeAt);
            if (divBus.Start) divBus.Dividend = $urandom;
            @(negedge Clk);
            cyc++;
        end
        expRes = exp_q.pop_front();
        checkVal("latency", XLEN'(cyc), XLEN'(lat));
        checkVal("busy_during_op", XLEN'(busyGaps), 0);
        if (divBus.Done) begin
            checkVal("result", divBus.Result, expRes);
            checkVal("addr_rd_out", XLEN'(divBus.AddrRdOut), XLEN'(rd));
            checkVal("regwrite", XLEN'(divBus.RegWrite), XLEN'(rd != 0));
            checkVal("busy_at_done", XLEN'(divBus.Busy), 1);
        end
        // A Start in the Done cycle must be ignored.
        drive(op, a, b, rd);
        @(negedge Clk);
        divBus.Start = 1'b0;
        checkVal("done_one_cycle", XLEN'(divBus.Done), 0);
        checkVal("busy_after_done", XLEN'(divBus.Busy), 0);
        checkVal("result_held", divBus.Result, expRes);
    endtask

    task automatic countDone(input int cycles, output int hits);
        hits = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge Clk);
            if (divBus.Done) hits++;
        end
    endtask

    initial begin
        int hits;
        int cyc;
        logic [XLEN-1:0] prevRes;
        logic [REG_AW-1:0] prevRd;
        logic [1:0] op;
        logic [XLEN-1:0] a, b;
        divBus.Start    = 1'b0;
        divBus.Flush    = 1'b0;
        divBus.Op       = 2'b00;
        divBus.Dividend = '0;
        divBus.Divisor  = '0;
        divBus.AddrRdIn = '0;
        repeat (2) @(negedge Clk);
        checkVal("rst_busy", XLEN'(divBus.Busy), 0);
        checkVal("rst_done", XLEN'(divBus.Done), 0);
        checkVal("rst_regwrite", XLEN'(divBus.RegWrite), 0);
        checkVal("rst_result", divBus.Result, 0);
        checkVal("rst_addr", XLEN'(divBus.AddrRdOut), 0);
        checkVal("rst_state", XLEN'(dbgState), 0);
        Rst = 1'b0;
        @(negedge Clk);

        runOp(2'b00, 32'd100, 32'd7, 5'd5, 0);
        runOp(2'b10, 32'd100, 32'd7, 5'd6, 0);
        runOp(2'b10, -32'sd100, 32'd7, 5'd7, 0);
        runOp(2'b00, -32'sd100, 32'd7, 5'd8, 0);
        runOp(2'b01, 32'hFFFF_FFFF, 32'd2, 5'd9, 0);
        runOp(2'b01, 32'd5, 32'd0, 5'd10, 0);
        runOp(2'b10, 32'd5, 32'd0, 5'd11, 0);
        runOp(2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 5'd12, 0);
        runOp(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 5'd13, 0);
        runOp(2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 5'd14, 0);
        runOp(2'b00, 32'd100, 32'd7, 5'd0, 0);

        // Stray Start mid-op: exactly one Done.
        runOp(2'b01, 32'd1000, 32'd3, 5'd9, 5);
        countDone(40, hits);
        checkVal("stray_start_done", XLEN'(hits), 0);

        // Flush together with Start in IDLE drops the Start.
        drive(2'b00, 32'd50, 32'd5, 5'd4);
        divBus.Flush = 1'b1;
        @(negedge Clk);
        divBus.Start = 1'b0;
        divBus.Flush = 1'b0;
        checkVal("flush_start_busy", XLEN'(divBus.Busy), 0);

        // Flush mid-op at cycle 10.
        prevRes = divBus.Result;
        prevRd  = divBus.AddrRdOut;
        hits    = 0;
        drive(2'b00, 32'd12345, 32'd67, 5'd3);
        @(posedge Clk);
        @(negedge Clk);
        divBus.Start = 1'b0;
        for (cyc = 1; cyc < 10; cyc++) begin
            @(negedge Clk);
            if (divBus.Done) hits++;
        end
        divBus.Flush = 1'b1;
        @(negedge Clk);
        divBus.Flush = 1'b0;
        checkVal("flush_busy", XLEN'(divBus.Busy), 0);
        checkVal("flush_done", XLEN'(hits + int'(divBus.Done)), 0);
        checkVal("flush_result", divBus.Result, prevRes);
        checkVal("flush_addr", XLEN'(divBus.AddrRdOut), XLEN'(prevRd));
        runOp(2'b10, 32'd12345, 32'd67, 5'd21, 0);

        // Asynchronous reset at cycle 20 of an op.
        drive(2'b00, 32'd999, 32'd9, 5'd17);
        @(posedge Clk);
        @(negedge Clk);
        divBus.Start = 1'b0;
        repeat (19) @(negedge Clk);
        #2 Rst = 1'b1;
        #1;
        checkVal("arst_busy", XLEN'(divBus.Busy), 0);
        checkVal("arst_done", XLEN'(divBus.Done), 0);
        checkVal("arst_result", divBus.Result, 0);
        checkVal("arst_addr", XLEN'(divBus.AddrRdOut), 0);
        checkVal("arst_regwrite", XLEN'(divBus.RegWrite), 0);
        @(negedge Clk);
        Rst = 1'b0;
        countDone(40, hits);
        checkVal("arst_no_done", XLEN'(hits), 0);

        // Random ops with a bias toward the special cases.
        for (int n = 0; n < 40; n++) begin
            op = 2'($urandom_range(0, 3));
            a  = $urandom;
            b  = $urandom;
            case ($urandom_range(0, 7))
                0: b = 32'd0;
                1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
                2: b = 32'($urandom_range(1, 15));
                3: b = -32'($urandom_range(1, 15));
                default: ;
            endcase
            runOp(op, a, b, 5'($urandom_range(0, 31)), 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiss);
        $finish;
    end
endmodule
